// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider (clk_div_prog).
package clk_div_pkg;

  localparam int DIV_W_DFLT = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_BYP  = 2'd2
  } state_e;

  // Counter values strictly below this threshold drive the high phase.
  function automatic int unsigned duty_thresh(input int unsigned div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for clk_div_prog: counts 0..cur_div-1 and flags the wrap
// (period boundary) and high-phase cycles.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] cur_div,
  output logic             wrap,
  output logic             high
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    wrap  = (cnt_q == cur_div - DIV_W'(1));
    high  = (32'(cnt_q) < duty_thresh(32'(cur_div)));
    cnt_d = (clr || wrap) ? '0 : cnt_q + DIV_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with req/ack divisor updates and bypass.
// Optional macro CLK_DIV_CUR_OUT_EN adds the o_CUR_DIV port (registered divisor).
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             i_SRC_CLK,
  input  logic             i_RESET,
  input  logic             i_DIV_REQ,
  input  logic [DIV_W-1:0] i_DIV_VAL,
  output logic             o_DIV_ACK,
  output logic             o_DIV_ERR,
  input  logic             i_BYPASS,
  output logic             o_BYP_ACT,
  output logic             o_CLK_DIV,
  output logic             o_CLK_EN
`ifdef CLK_DIV_CUR_OUT_EN
  ,
  output logic [DIV_W-1:0] o_CUR_DIV
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             req_prev_q, req_prev_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;
  logic             byp_act_q, byp_act_d;
  logic             clk_div_q, clk_div_d;
  logic             clk_en_q, clk_en_d;

  logic             cnt_clr;
  logic             wrap;
  logic             high;
  logic             req_rise;
  logic             req_zero;
  logic             boundary;

  clk_div_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk     (i_SRC_CLK),
    .rst     (i_RESET),
    .clr     (cnt_clr),
    .cur_div (cur_div_q),
    .wrap    (wrap),
    .high    (high)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    div_ack_d  = 1'b0;
    div_err_d  = 1'b0;
    cnt_clr    = 1'b0;
    req_prev_d = i_DIV_REQ;

    req_rise = i_DIV_REQ & ~req_prev_q;
    req_zero = (i_DIV_VAL == '0);
    boundary = wrap & (state_q != ST_BYP);

    unique case (state_q)
      ST_RUN: begin
        if (req_rise && req_zero) begin
          div_ack_d = 1'b1;
          div_err_d = 1'b1;
        end
        // A request landing on the boundary cycle is applied at this boundary.
        if (boundary) begin
          if (req_rise && !req_zero) begin
            cur_div_d = i_DIV_VAL;
            div_ack_d = 1'b1;
            cnt_clr   = 1'b1;
          end
          if (i_BYPASS) begin
            state_d = ST_BYP;
          end
        end else if (req_rise && !req_zero) begin
          pend_div_d = i_DIV_VAL;
          state_d    = ST_PEND;
        end
      end

      ST_PEND: begin
        if (boundary) begin
          cur_div_d  = pend_div_q;
          pend_div_d = '0;
          div_ack_d  = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = i_BYPASS ? ST_BYP : ST_RUN;
        end
      end

      ST_BYP: begin
        cnt_clr = 1'b1;
        if (req_rise) begin
          div_ack_d = 1'b1;
          div_err_d = req_zero;
          if (!req_zero) begin
            cur_div_d = i_DIV_VAL;
          end
        end
        if (!i_BYPASS) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    clk_en_d  = boundary | (state_q == ST_BYP);
    clk_div_d = high & (state_q != ST_BYP);
    byp_act_d = (state_d == ST_BYP);
  end

  always_ff @(posedge i_SRC_CLK) begin
    if (i_RESET) begin
      state_q    <= ST_RUN;
      cur_div_q  <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      div_ack_q  <= 1'b0;
      div_err_q  <= 1'b0;
      byp_act_q  <= 1'b0;
      clk_div_q  <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      div_ack_q  <= div_ack_d;
      div_err_q  <= div_err_d;
      byp_act_q  <= byp_act_d;
      clk_div_q  <= clk_div_d;
      clk_en_q   <= clk_en_d;
    end
    // Tracks the request line through reset so a request held across reset is not seen as new.
    req_prev_q <= req_prev_d;
  end

  assign o_DIV_ACK = div_ack_q;
  assign o_DIV_ERR = div_err_q;
  assign o_BYP_ACT = byp_act_q;
  assign o_CLK_DIV = clk_div_q;
  assign o_CLK_EN  = clk_en_q;

`ifdef CLK_DIV_CUR_OUT_EN
  assign o_CUR_DIV = cur_div_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed steps plus random traffic
// against a cycle-level behavioural model of the divider.
module tb_clk_div_prog;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic [DIV_W-1:0] val;
  logic             byp;
  logic             ack;
  logic             err;
  logic             byp_act;
  logic             clk_div;
  logic             clk_en;
`ifdef CLK_DIV_CUR_OUT_EN
  logic [DIV_W-1:0] cur_div;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_prog #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .i_SRC_CLK (clk),
    .i_RESET   (rst),
    .i_DIV_REQ (req),
    .i_DIV_VAL (val),
    .o_DIV_ACK (ack),
    .o_DIV_ERR (err),
    .i_BYPASS  (byp),
    .o_BYP_ACT (byp_act),
    .o_CLK_DIV (clk_div),
    .o_CLK_EN  (clk_en)
`ifdef CLK_DIV_CUR_OUT_EN
    ,
    .o_CUR_DIV (cur_div)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: position within the period, active divisor, pending
  // divisor (0 = none) and a bypass flag; outputs are what the next edge shows.
  int   m_phase    = 0;
  int   m_div      = DEFAULT_DIV;
  int   m_pend     = 0;
  bit   m_byp      = 1'b0;
  bit   m_req_prev = 1'b0;
  logic e_en, e_clk, e_ack, e_err, e_byp;

  task automatic model_step();
    bit new_req;
    new_req    = req && !m_req_prev;
    m_req_prev = req;
    e_ack      = 1'b0;
    e_err      = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_div   = DEFAULT_DIV;
      m_pend  = 0;
      m_byp   = 1'b0;
      e_en    = 1'b0;
      e_clk   = 1'b0;
      e_byp   = 1'b0;
    end else if (m_byp) begin
      e_en  = 1'b1;
      e_clk = 1'b0;
      if (new_req) begin
        e_ack = 1'b1;
        if (val == 0) e_err = 1'b1;
        else          m_div = int'(val);
      end
      if (!byp) begin
        m_byp   = 1'b0;
        m_phase = 0;
      end
      e_byp = m_byp;
    end else begin
      e_en  = (m_phase == m_div - 1);
      e_clk = (m_phase < m_div / 2);
      if (new_req && m_pend == 0) begin
        if (val == 0) begin
          e_ack = 1'b1;
          e_err = 1'b1;
        end else begin
          m_pend = int'(val);
        end
      end
      if (m_phase == m_div - 1) begin
        m_phase = 0;
        if (m_pend != 0) begin
          m_div  = m_pend;
          m_pend = 0;
          e_ack  = 1'b1;
        end
        if (byp) m_byp = 1'b1;
      end else begin
        m_phase++;
      end
      e_byp = m_byp;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("clk_en",  clk_en,  e_en);
    check("clk_div", clk_div, e_clk);
    check("div_ack", ack,     e_ack);
    check("div_err", err,     e_err);
    check("byp_act", byp_act, e_byp);
`ifdef CLK_DIV_CUR_OUT_EN
    check("cur_div", cur_div, m_div);
`endif
  endtask

  task automatic wait_ack(input int max_cycles, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      cycle();
      seen = ack;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    logic [3:0] clk_pat;
    logic [3:0] en_pat;
    int         cnt_a;
    int         cnt_b;
    int         cnt_c;
    int         wait_n;

    rst = 1'b1;
    req = 1'b0;
    val = '0;
    byp = 1'b0;
    repeat (3) cycle();
    check("rst_outs", {ack, err, byp_act, clk_div, clk_en}, 0);

    // Default divide-by-2 after reset release.
    rst     = 1'b0;
    clk_pat = 4'b0101;
    en_pat  = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("boot_clk", clk_div, clk_pat[i]);
      check("boot_en",  clk_en,  en_pat[i]);
    end

    // N=5 requested mid-period; then 2 high / 3 low, enable every 5.
    req = 1'b1;
    val = 8'd5;
    wait_ack(10, "n5_ack");
    req   = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    repeat (15) begin
      cycle();
      cnt_a += int'(clk_en);
      cnt_b += int'(clk_div);
    end
    check("n5_en_count", cnt_a, 3);
    check("n5_hi_count", cnt_b, 6);

    // N=0 is rejected one cycle after acceptance.
    req = 1'b1;
    val = 8'd0;
    cycle();
    check("n0_ack", ack, 1);
    check("n0_err", err, 1);
    cycle();
    check("n0_ack_once", ack, 0);
    req = 1'b0;
    cycle();

    // N=4, bypass raised at cnt=1, then released.
    req = 1'b1;
    val = 8'd4;
    wait_ack(12, "n4_ack");
    req = 1'b0;
    cycle();
    byp    = 1'b1;
    wait_n = 0;
    do begin
      cycle();
      wait_n++;
    end while (!byp_act && wait_n < 10);
    check("byp_entry_lat", wait_n, 3);
    repeat (5) begin
      cycle();
      check("byp_en_const", clk_en, 1);
      check("byp_clk_low",  clk_div, 0);
    end
    byp = 1'b0;
    cycle();
    wait_n = 0;
    do begin
      cycle();
      wait_n++;
    end while (!clk_en && wait_n < 10);
    check("byp_exit_lat", wait_n, 4);

    // Reset while N=7 is pending: no ack, defaults restored.
    req = 1'b1;
    val = 8'd7;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check("pend_rst_outs", {ack, err, byp_act, clk_div, clk_en}, 0);
`ifdef CLK_DIV_CUR_OUT_EN
    check("pend_rst_cur", cur_div, DEFAULT_DIV);
`endif
    rst   = 1'b0;
    cnt_a = 0;
    repeat (12) begin
      cycle();
      cnt_a += int'(ack);
    end
    check("pend_rst_no_ack", cnt_a, 0);
    req = 1'b0;
    cycle();

    // N=1: enable stuck high, clock stuck low, held request not re-acked.
    req = 1'b1;
    val = 8'd1;
    wait_ack(8, "n1_ack");
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    repeat (10) begin
      cycle();
      cnt_a += int'(ack);
      cnt_b += int'(clk_en);
      cnt_c += int'(clk_div);
    end
    check("n1_no_second_ack", cnt_a, 0);
    check("n1_en_count",      cnt_b, 10);
    check("n1_hi_count",      cnt_c, 0);
    req = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (req && (ack || $urandom_range(0, 63) == 0)) begin
        req = 1'b0;
      end else if (!req && $urandom_range(0, 5) == 0) begin
        req = 1'b1;
        if ($urandom_range(0, 15) == 0) val = DIV_W'($urandom_range(0, 40));
        else                            val = DIV_W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 39) == 0) byp = ~byp;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
